// File: rtl/audio_sample_sched.sv
// Sample scheduler: buffers producer samples in a small FIFO and releases one
// to the PWM sample input every PERIOD clocks, flagging underruns when starved.
module audio_sample_sched #(
    parameter int          PERIOD     = 255,
    parameter int          DEPTH      = 4,
    parameter logic [7:0]  IDLE_LEVEL = 8'h80
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic [7:0]                 sample_out,
    output logic                       sample_strobe,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       underrun,
    input  logic                       underrun_clr
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [FW-1:0] FULL     = FW'(DEPTH);

    logic [CW-1:0] cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          boundary, push, pop, empty;

    assign empty    = (fill_level == '0);
    assign in_ready = rst_n && en && (fill_level < FULL);
    assign boundary = en && (cnt == CNT_LAST);
    assign push     = in_valid && in_ready;
    // A sample pushed into an empty FIFO during a boundary is not visible to the pop.
    assign pop      = boundary && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            sample_out    <= IDLE_LEVEL;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else if (!en) begin
            cnt           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            sample_out    <= IDLE_LEVEL;
            sample_strobe <= 1'b0;
            if (underrun_clr)
                underrun <= 1'b0;
        end else begin
            cnt           <= boundary ? '0 : cnt + 1'b1;
            sample_strobe <= boundary;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                sample_out <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            // Set beats clear when a starved boundary coincides with underrun_clr.
            if (boundary && empty)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_sample_sched.sv
// Directed bench for audio_sample_sched at default parameters (PERIOD=255, DEPTH=4).
module tb_audio_sample_sched;
    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, underrun_clr;
    logic [7:0] in_data;
    logic       in_ready, sample_strobe, underrun;
    logic [7:0] sample_out;
    logic [2:0] fill_level;
    int         checks = 0;
    int         errors = 0;
    int         s;

    audio_sample_sched dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sample_out(sample_out), .sample_strobe(sample_strobe),
        .fill_level(fill_level), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance n edges, counting strobes seen after each edge.
    task automatic run(input int n, output int strobes);
        strobes = 0;
        repeat (n) begin
            step();
            if (sample_strobe === 1'b1) strobes++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; underrun_clr = 1'b0;
        #1;
        chk("ready_in_reset", in_ready, 0);
        step(); step();
        chk("rst_fill", fill_level, 0);
        chk("rst_sample", sample_out, 8'h80);
        chk("rst_strobe", sample_strobe, 0);
        chk("rst_underrun", underrun, 0);

        // Basic playback: two samples, first strobe on the 255th enabled edge.
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h10;
        #1; chk("ready_en", in_ready, 1);
        step(); in_data = 8'h20;
        step(); in_valid = 1'b0;
        chk("fill_2", fill_level, 2);
        run(252, s);
        chk("no_early_strobe", s, 0);
        chk("idle_before_first", sample_out, 8'h80);
        step();
        chk("strobe_1", sample_strobe, 1);
        chk("sample_10", sample_out, 8'h10);
        chk("fill_1", fill_level, 1);
        step();
        chk("strobe_one_cycle", sample_strobe, 0);
        run(253, s);
        chk("spacing_quiet", s, 0);
        step();
        chk("strobe_2", sample_strobe, 1);
        chk("sample_20", sample_out, 8'h20);
        chk("fill_0", fill_level, 0);

        // Underrun: held sample, strobe, sticky flag; set beats clear.
        run(254, s);
        step();
        chk("ur_strobe", sample_strobe, 1);
        chk("ur_hold", sample_out, 8'h20);
        chk("ur_set", underrun, 1);
        underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
        chk("ur_clr", underrun, 0);
        run(253, s);
        underrun_clr = 1'b1;
        step(); underrun_clr = 1'b0;
        chk("ur_set_wins", underrun, 1);
        chk("ur_strobe2", sample_strobe, 1);
        underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
        chk("ur_clr2", underrun, 0);

        // Push into empty FIFO exactly in a boundary cycle.
        run(253, s);
        in_valid = 1'b1; in_data = 8'hAA;
        #1; chk("ready_bnd_empty", in_ready, 1);
        step(); in_valid = 1'b0;
        chk("aa_underrun", underrun, 1);
        chk("aa_fill", fill_level, 1);
        chk("aa_hold", sample_out, 8'h20);
        run(254, s);
        step();
        chk("aa_strobe", sample_strobe, 1);
        chk("aa_out", sample_out, 8'hAA);
        chk("aa_fill0", fill_level, 0);

        // Back-to-back pushes: fifth refused until the next pop.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h31 + 8'(i);
            step();
        end
        in_data = 8'h35;
        #1;
        chk("full_fill", fill_level, 4);
        chk("full_ready", in_ready, 0);
        run(250, s);
        #1; chk("full_ready_bnd", in_ready, 0);
        step();
        chk("pop_31", sample_out, 8'h31);
        chk("pop_fill3", fill_level, 3);
        #1; chk("ready_after_pop", in_ready, 1);
        step(); in_valid = 1'b0;
        chk("fifth_in", fill_level, 4);

        // Simultaneous push and pop at a boundary.
        run(253, s);
        step();
        chk("pop_32", sample_out, 8'h32);
        run(254, s);
        in_valid = 1'b1; in_data = 8'h66;
        step(); in_valid = 1'b0;
        chk("pp_fill", fill_level, 3);
        chk("pp_out", sample_out, 8'h33);

        // Disable mid-period with fill 3, then re-enable.
        run(10, s);
        en = 1'b0;
        #1; chk("ready_dis", in_ready, 0);
        step();
        chk("dis_fill", fill_level, 0);
        chk("dis_sample", sample_out, 8'h80);
        chk("dis_strobe", sample_strobe, 0);
        in_valid = 1'b1; in_data = 8'h77;
        step(); in_valid = 1'b0;
        chk("dis_no_push", fill_level, 0);
        chk("dis_ur_hold", underrun, 1);
        underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
        chk("dis_ur_clr", underrun, 0);
        en = 1'b1;
        run(254, s);
        chk("reen_quiet", s, 0);
        step();
        chk("reen_strobe", sample_strobe, 1);
        chk("reen_ur", underrun, 1);
        chk("reen_hold", sample_out, 8'h80);

        // Reset with a full FIFO and underrun set.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h50 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_fill", fill_level, 4);
        rst_n = 1'b0;
        #1; chk("rst_ready", in_ready, 0);
        step(); rst_n = 1'b1;
        chk("rst2_fill", fill_level, 0);
        chk("rst2_sample", sample_out, 8'h80);
        chk("rst2_strobe", sample_strobe, 0);
        chk("rst2_underrun", underrun, 0);
        run(254, s);
        chk("rst2_quiet", s, 0);
        step();
        chk("rst2_first_strobe", sample_strobe, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
